// File: rtl/s_box_layer_serial.sv
`default_nettype none
// ============================================================================
// Module   : s_box_layer_serial
// Brief    : Iterative BORON S-box layer; LANES nibbles are substituted per
//            cycle over a WIDTH-bit state. The inverse table is built only
//            when SBOX_LAYER_INV_EN is defined.
// Revision : 1.0
// ============================================================================
module s_box_layer_serial #(
    parameter int WIDTH = 64,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] cipherIn,
    input  logic             decMode,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sBoxLayerOut,
    output logic             busy
);

    localparam int STEPS = WIDTH / (4 * LANES);
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int SLICE = 4 * LANES;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SLICE-1:0] w_sub;
    logic [WIDTH-1:0] w_next;
    logic             w_mode_in;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'hE;  4'h1: r = 4'h4;  4'h2: r = 4'hB;  4'h3: r = 4'h1;
            4'h4: r = 4'h7;  4'h5: r = 4'h9;  4'h6: r = 4'hC;  4'h7: r = 4'hA;
            4'h8: r = 4'hD;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'hF;
            4'hC: r = 4'h8;  4'hD: r = 4'h5;  4'hE: r = 4'h3;  default: r = 4'h6;
        endcase
        return r;
    endfunction

`ifdef SBOX_LAYER_INV_EN
    function automatic logic [3:0] sbox_inv(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'hA;  4'h1: r = 4'h3;  4'h2: r = 4'h9;  4'h3: r = 4'hE;
            4'h4: r = 4'h1;  4'h5: r = 4'hD;  4'h6: r = 4'hF;  4'h7: r = 4'h4;
            4'h8: r = 4'hC;  4'h9: r = 4'h5;  4'hA: r = 4'h7;  4'hB: r = 4'h2;
            4'hC: r = 4'h6;  4'hD: r = 4'h8;  4'hE: r = 4'h0;  default: r = 4'hB;
        endcase
        return r;
    endfunction

    assign w_mode_in = decMode;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_sub[4*l +: 4] = mode_q ? sbox_inv(data_q[4*l +: 4])
                                        : sbox_fwd(data_q[4*l +: 4]);
    end
`else
    // Forward-only build: the mode register is held at zero.
    logic [1:0] w_unused_mode;
    assign w_unused_mode = {decMode, mode_q};
    assign w_mode_in     = 1'b0;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_sub[4*l +: 4] = sbox_fwd(data_q[4*l +: 4]);
    end
`endif

    // Rotate the substituted slice in at the top so nibbles return home after STEPS cycles.
    if (STEPS == 1) begin : g_single
        assign w_next = w_sub;
    end else begin : g_multi
        assign w_next = {w_sub, data_q[WIDTH-1:SLICE]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (inValid) begin
                    data_d  = cipherIn;
                    mode_d  = w_mode_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                data_d = w_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (outReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    assign inReady      = (state_q == S_IDLE);
    assign outValid     = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign sBoxLayerOut = data_q;

endmodule
`default_nettype wire
